// File: rtl/layer_ctrl.sv
// Sequencing controller for one convolution layer: launches the picture source
// once per kernel pass, tracks pixel/result counts and raises done or fault.
module layer_ctrl #(
  parameter int NUM_KERNELS  = 4,
  parameter int PIX_PER_PIC  = 784,
  parameter int OUT_PER_PASS = 676,
  parameter int TIMEOUT      = 4096,
  parameter int KW           = (NUM_KERNELS > 1) ? $clog2(NUM_KERNELS) : 1,
  parameter int AW           = KW + $clog2(OUT_PER_PASS)
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          start_flag,
  input  logic          pic_valid,
  input  logic          out_valid,
  output logic          pic_start,
  output logic [KW-1:0] kernel_sel,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic          busy,
  output logic          layer_done,
  output logic          err
);

  localparam int OW = AW - KW;
  localparam int PW = $clog2(PIX_PER_PIC + 1);
  localparam int TW = $clog2(TIMEOUT);

  localparam logic [OW-1:0] OUT_LAST = OW'(OUT_PER_PASS - 1);
  localparam logic [OW-1:0] OUT_ONE  = OW'(1);
  localparam logic [PW-1:0] PIX_MAX  = PW'(PIX_PER_PIC);
  localparam logic [PW-1:0] PIX_ONE  = PW'(1);
  localparam logic [TW-1:0] WD_LAST  = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] WD_ONE   = TW'(1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_KERNELS - 1);
  localparam logic [KW-1:0] K_ONE    = KW'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LAUNCH   = 3'd1,
    S_STREAM   = 3'd2,
    S_PASS_END = 3'd3,
    S_DONE     = 3'd4,
    S_ERR      = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] kernel_q, kernel_d;
  logic [PW-1:0] pix_cnt_q, pix_cnt_d;
  logic [OW-1:0] out_cnt_q, out_cnt_d;
  logic [TW-1:0] wd_cnt_q, wd_cnt_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          err_q, err_d;

  // State and datapath registers with synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      kernel_q  <= '0;
      pix_cnt_q <= '0;
      out_cnt_q <= '0;
      wd_cnt_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      kernel_q  <= kernel_d;
      pix_cnt_q <= pix_cnt_d;
      out_cnt_q <= out_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      err_q     <= err_d;
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_d   = state_q;
    kernel_d  = kernel_q;
    pix_cnt_d = pix_cnt_q;
    out_cnt_d = out_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start_flag) begin
          state_d   = S_LAUNCH;
          err_d     = 1'b0;
          kernel_d  = '0;
          pix_cnt_d = '0;
          out_cnt_d = '0;
          wd_cnt_d  = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LAUNCH: begin
        state_d = S_STREAM;
      end
      S_STREAM: begin
        // A result strobe both services the watchdog and may end the pass.
        if (out_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {kernel_q, out_cnt_q};
          wd_cnt_d  = '0;
          if (out_cnt_q == OUT_LAST) begin
            out_cnt_d = '0;
            state_d   = S_PASS_END;
          end else begin
            out_cnt_d = out_cnt_q + OUT_ONE;
          end
        end else if (wd_cnt_q == WD_LAST) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_ONE;
        end
        // Overrun is checked last so it overrides a pass end in the same cycle.
        if (pic_valid) begin
          if (pix_cnt_q == PIX_MAX) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            pix_cnt_d = pix_cnt_q + PIX_ONE;
          end
        end else begin
          pix_cnt_d = pix_cnt_q;
        end
      end
      S_PASS_END: begin
        pix_cnt_d = '0;
        out_cnt_d = '0;
        wd_cnt_d  = '0;
        if (kernel_q == K_LAST) begin
          state_d = S_DONE;
        end else begin
          kernel_d = kernel_q + K_ONE;
          state_d  = S_LAUNCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      S_ERR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign pic_start  = (state_q == S_LAUNCH);
  assign busy       = (state_q == S_LAUNCH) || (state_q == S_STREAM) ||
                      (state_q == S_PASS_END) || (state_q == S_DONE);
  assign layer_done = (state_q == S_DONE);
  assign kernel_sel = kernel_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign err        = err_q;

endmodule

// File: tb/tb_layer_ctrl.sv
// Randomized self-checking bench for layer_ctrl; a second instance covers the
// single-kernel build on the same stimulus.
module tb_layer_ctrl;

  localparam int NK  = 2;
  localparam int PIX = 9;
  localparam int OUT = 4;
  localparam int TO  = 16;
  localparam int KW  = 1;
  localparam int AW  = 3;

  logic          clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          start_flag = 1'b0;
  logic          pic_valid = 1'b0;
  logic          out_valid = 1'b0;
  logic          pic_start, wr_en, busy, layer_done, err;
  logic [KW-1:0] kernel_sel;
  logic [AW-1:0] wr_addr;
  logic          pic_start1, wr_en1, busy1, layer_done1, err1;
  logic [0:0]    kernel_sel1;
  logic [2:0]    wr_addr1;

  int checks = 0;
  int failures = 0;
  logic [AW-1:0] act_q[$];
  logic [2:0]    act1_q[$];
  int n_start = 0;
  int n_done = 0;
  int n_done1 = 0;

  layer_ctrl #(.NUM_KERNELS(NK), .PIX_PER_PIC(PIX), .OUT_PER_PASS(OUT), .TIMEOUT(TO)) u_dut (
    .sys_clk(clk), .sys_rst(sys_rst), .start_flag(start_flag), .pic_valid(pic_valid),
    .out_valid(out_valid), .pic_start(pic_start), .kernel_sel(kernel_sel), .wr_en(wr_en),
    .wr_addr(wr_addr), .busy(busy), .layer_done(layer_done), .err(err));

  layer_ctrl #(.NUM_KERNELS(1), .PIX_PER_PIC(PIX), .OUT_PER_PASS(OUT), .TIMEOUT(TO)) u_dut1 (
    .sys_clk(clk), .sys_rst(sys_rst), .start_flag(start_flag), .pic_valid(pic_valid),
    .out_valid(out_valid), .pic_start(pic_start1), .kernel_sel(kernel_sel1), .wr_en(wr_en1),
    .wr_addr(wr_addr1), .busy(busy1), .layer_done(layer_done1), .err(err1));

  always #5 clk = ~clk;

  // Record pulses and writes mid-cycle
  always @(negedge clk) begin
    if (wr_en === 1'b1) act_q.push_back(wr_addr);
    if (wr_en1 === 1'b1) act1_q.push_back(wr_addr1);
    if (pic_start === 1'b1) n_start++;
    if (layer_done === 1'b1) n_done++;
    if (layer_done1 === 1'b1) n_done1++;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    sys_rst = 1'b1; start_flag = 1'b0; pic_valid = 1'b0; out_valid = 1'b0;
    tick(); tick();
    sys_rst = 1'b0;
  endtask

  // One pass of strobes: all pixels arrive before the final result; result gaps stay well under TO.
  task automatic stream_pass(input int lead, input bit extra);
    int np, no, gap;
    bit pv, ov, sent;
    np = 0; no = 0; gap = lead; sent = 1'b0;
    repeat (lead) tick();
    while (no < OUT) begin
      if (no < OUT - 1) begin
        pv = (np < PIX) && ($urandom_range(0, 1) == 1);
        ov = ($urandom_range(0, 2) == 0) || (gap >= 10);
      end else begin
        pv = (np < PIX);
        ov = (np == PIX);
      end
      if (lead > 0 && no == 0) begin pv = 1'b0; ov = 1'b1; end
      start_flag = extra && (no == 1) && !sent;
      if (start_flag) sent = 1'b1;
      pic_valid = pv; out_valid = ov;
      tick();
      if (pv) np++;
      if (ov) begin no++; gap = 0; end else gap++;
    end
    pic_valid = 1'b0; out_valid = 1'b0; start_flag = 1'b0;
  endtask

  task automatic run_layer(input bit extra, input int lead);
    int base, s0, d0, lat, got, exp;
    bit found;
    base = act_q.size(); s0 = n_start; d0 = n_done;
    for (int k = 0; k < NK; k++) begin
      if (k == 0) begin
        start_flag = 1'b1; tick(); start_flag = 1'b0;
        lat = 1; found = pic_start;
      end else begin
        found = 1'b0; lat = 0;
        while (!found && lat < 6) begin tick(); lat++; found = pic_start; end
      end
      checks++;
      if (!found || lat != 1) begin
        failures++; $display("FAIL launch_latency pass %0d: got %0d cycles (seen=%0d) expected 1", k, lat, found);
      end
      checks++;
      if (kernel_sel !== KW'(k)) begin
        failures++; $display("FAIL kernel_sel pass %0d: got %0d expected %0d", k, kernel_sel, k);
      end
      if (!found) return;
      tick();
      stream_pass((k == 0) ? lead : 0, extra && (k == 0));
      checks++;
      if (err !== 1'b0) begin
        failures++; $display("FAIL err_in_pass %0d: got %b expected 0", k, err);
      end
    end
    lat = 0;
    while (busy === 1'b1 && lat < 6) begin tick(); lat++; end
    checks++;
    if (lat != 2 || busy !== 1'b0) begin
      failures++; $display("FAIL busy_drop: got %0d cycles busy=%b expected 2 cycles busy=0", lat, busy);
    end
    got = act_q.size() - base;
    checks++;
    if (got != NK * OUT) begin
      failures++; $display("FAIL write_count: got %0d expected %0d", got, NK * OUT);
    end else begin
      for (int i = 0; i < NK * OUT; i++) begin
        exp = (i / OUT) * OUT + (i % OUT);
        checks++;
        if (act_q[base + i] !== AW'(exp)) begin
          failures++; $display("FAIL wr_addr[%0d]: got %0d expected %0d", i, act_q[base + i], exp);
        end
      end
    end
    checks++;
    if (n_start - s0 != NK) begin
      failures++; $display("FAIL pic_start_count: got %0d expected %0d", n_start - s0, NK);
    end
    checks++;
    if (n_done - d0 != 1) begin
      failures++; $display("FAIL layer_done_count: got %0d expected 1", n_done - d0);
    end
    checks++;
    if (err !== 1'b0) begin
      failures++; $display("FAIL err_end: got %b expected 0", err);
    end
  endtask

  task automatic test_reset();
    int base;
    sys_rst = 1'b1; start_flag = 1'b0; pic_valid = 1'b0; out_valid = 1'b0;
    tick();
    checks++;
    if ({pic_start, kernel_sel, wr_en, wr_addr, busy, layer_done, err} !== 9'd0) begin
      failures++; $display("FAIL reset_outputs: got %b expected 0", {pic_start, kernel_sel, wr_en, wr_addr, busy, layer_done, err});
    end
    checks++;
    if ({pic_start1, kernel_sel1, wr_en1, wr_addr1, busy1, layer_done1, err1} !== 9'd0) begin
      failures++; $display("FAIL reset_outputs_nk1: got %b expected 0", {pic_start1, kernel_sel1, wr_en1, wr_addr1, busy1, layer_done1, err1});
    end
    sys_rst = 1'b0;
    base = act_q.size();
    pic_valid = 1'b1; out_valid = 1'b1;
    repeat (5) tick();
    pic_valid = 1'b0; out_valid = 1'b0;
    tick();
    checks++;
    if (act_q.size() != base || busy !== 1'b0) begin
      failures++; $display("FAIL idle_strobes: got %0d writes busy=%b expected 0 writes busy=0", act_q.size() - base, busy);
    end
  endtask

  task automatic test_nominal();
    int b1, d1;
    do_reset();
    repeat (10) tick();
    b1 = act1_q.size(); d1 = n_done1;
    run_layer(1'b0, 0);
    checks++;
    if (act1_q.size() - b1 != OUT) begin
      failures++; $display("FAIL nk1_write_count: got %0d expected %0d", act1_q.size() - b1, OUT);
    end else begin
      for (int i = 0; i < OUT; i++) begin
        checks++;
        if (act1_q[b1 + i] !== 3'(i)) begin
          failures++; $display("FAIL nk1_wr_addr[%0d]: got %0d expected %0d", i, act1_q[b1 + i], i);
        end
      end
    end
    checks++;
    if (n_done1 - d1 != 1) begin
      failures++; $display("FAIL nk1_layer_done: got %0d expected 1", n_done1 - d1);
    end
  endtask

  task automatic test_start_while_busy();
    do_reset();
    run_layer(1'b1, 0);
  endtask

  task automatic test_wd_boundary();
    do_reset();
    run_layer(1'b0, TO - 1);
  endtask

  task automatic test_timeout();
    int n, d0;
    do_reset();
    d0 = n_done;
    start_flag = 1'b1; tick(); start_flag = 1'b0;
    tick();
    stream_pass(0, 1'b0);
    n = 0;
    while (pic_start !== 1'b1 && n < 6) begin tick(); n++; end
    n = 0;
    while (err !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n != TO + 1) begin
      failures++; $display("FAIL timeout_cycle: got err after %0d cycles expected %0d", n, TO + 1);
    end
    checks++;
    if (busy !== 1'b0 || n_done != d0) begin
      failures++; $display("FAIL timeout_state: got busy=%b done=%0d expected busy=0 done=0", busy, n_done - d0);
    end
    tick();
    checks++;
    if (err !== 1'b1) begin
      failures++; $display("FAIL err_sticky: got %b expected 1", err);
    end
    start_flag = 1'b1; tick(); start_flag = 1'b0;
    checks++;
    if (err !== 1'b0 || kernel_sel !== 1'b0 || pic_start !== 1'b1) begin
      failures++; $display("FAIL restart: got err=%b kernel_sel=%0d pic_start=%b expected 0 0 1", err, kernel_sel, pic_start);
    end
  endtask

  task automatic test_overrun(input bit with_final);
    int base, s0, d0, nw;
    do_reset();
    base = act_q.size(); s0 = n_start; d0 = n_done;
    start_flag = 1'b1; tick(); start_flag = 1'b0;
    tick();
    for (int i = 0; i < PIX + 1; i++) begin
      pic_valid = 1'b1;
      out_valid = (i < OUT - 1) || (i == PIX && with_final);
      tick();
      if (i == PIX - 1) begin
        checks++;
        if (err !== 1'b0) begin
          failures++; $display("FAIL overrun_early: got err=%b expected 0 after %0d pixels", err, PIX);
        end
      end
    end
    pic_valid = 1'b0; out_valid = 1'b0;
    checks++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL overrun_err: got err=%b busy=%b expected 1 0", err, busy);
    end
    repeat (20) tick();
    nw = with_final ? OUT : OUT - 1;
    checks++;
    if (act_q.size() - base != nw) begin
      failures++; $display("FAIL overrun_writes: got %0d expected %0d", act_q.size() - base, nw);
    end else begin
      checks++;
      if (act_q[base + nw - 1] !== AW'(nw - 1)) begin
        failures++; $display("FAIL overrun_last_addr: got %0d expected %0d", act_q[base + nw - 1], nw - 1);
      end
    end
    checks++;
    if (n_start - s0 != 1 || n_done != d0 || err !== 1'b1) begin
      failures++; $display("FAIL overrun_after: got starts=%0d dones=%0d err=%b expected 1 0 1", n_start - s0, n_done - d0, err);
    end
  endtask

  task automatic test_reset_mid();
    int n, d0;
    do_reset();
    start_flag = 1'b1; tick(); start_flag = 1'b0;
    tick();
    stream_pass(0, 1'b0);
    n = 0;
    while (pic_start !== 1'b1 && n < 6) begin tick(); n++; end
    tick();
    d0 = n_done;
    pic_valid = 1'b1; out_valid = 1'b1;
    tick(); tick();
    pic_valid = 1'b0; out_valid = 1'b0; sys_rst = 1'b1;
    tick();
    checks++;
    if ({pic_start, kernel_sel, wr_en, wr_addr, busy, layer_done, err} !== 9'd0) begin
      failures++; $display("FAIL midreset_outputs: got %b expected 0", {pic_start, kernel_sel, wr_en, wr_addr, busy, layer_done, err});
    end
    sys_rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (n_done != d0 || busy !== 1'b0) begin
      failures++; $display("FAIL midreset_idle: got dones=%0d busy=%b expected 0 0", n_done - d0, busy);
    end
    run_layer(1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_start_while_busy();
    test_timeout();
    test_overrun(1'b0);
    test_overrun(1'b1);
    test_reset_mid();
    test_wd_boundary();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/layer_ctrl.md
Name: layer_ctrl

Overview:
Sequencing controller for one convolution layer (picture source + conv engine). On a start request it launches the picture generator once per kernel pass and selects the kernel for each pass. It counts pixels in and conv results out, generates result-buffer write addresses, and flags completion or fault. It sits between the top-level start logic and the pic_input/conv pair, replacing the direct start_flag wiring.

Parameters:
NUM_KERNELS, 4, number of kernel passes per layer (>=1)
PIX_PER_PIC, 784, pixels streamed per picture launch (28x28)
OUT_PER_PASS, 676, conv results expected per pass (26x26)
TIMEOUT, 4096, max cycles in STREAM without an out_valid before fault
KW, $clog2(NUM_KERNELS) (min 1), kernel index width
AW, KW+$clog2(OUT_PER_PASS), result address width

Ports:
sys_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  synchronous reset, active-high
start_flag  in  1  layer start request, sampled in IDLE only
pic_valid  in  1  pixel strobe from picture generator
out_valid  in  1  result strobe from conv engine
pic_start  out  1  one-cycle launch pulse to picture generator
kernel_sel  out  KW  kernel index for current pass
wr_en  out  1  result-buffer write strobe
wr_addr  out  AW  result-buffer address = {kernel_sel, out_cnt}
busy  out  1  high from LAUNCH through DONE/ERR exit
layer_done  out  1  one-cycle pulse, all passes complete
err  out  1  sticky fault flag

Behaviour:
- Reset (sys_clk edge with sys_rst=1): state=IDLE; pic_start=0, kernel_sel=0, wr_en=0, wr_addr=0, busy=0, layer_done=0, err=0; pix_cnt, out_cnt, wd_cnt cleared. Reset mid-pass aborts immediately; no pulse is emitted.
- States: IDLE, LAUNCH, STREAM, PASS_END, DONE, ERR. All outputs are registered or decoded from the state register only.
- IDLE: busy=0. If start_flag=1 at edge T: state=LAUNCH at T+1, err cleared, kernel_sel=0, counters cleared.
- LAUNCH: pic_start=1 for exactly this cycle, busy=1; next state STREAM. Latency from start_flag to pic_start is 1 cycle.
- STREAM:
  - Each pic_valid increments pix_cnt.
  - Each out_valid drives wr_en=1 and wr_addr={kernel_sel,out_cnt} in the following cycle (1-cycle registered), then increments out_cnt.
  - When out_valid arrives with out_cnt==OUT_PER_PASS-1, the next state is PASS_END.
  - wd_cnt clears on every out_valid and otherwise increments. If wd_cnt reaches TIMEOUT-1, the next state is ERR.
  - If pic_valid arrives with pix_cnt==PIX_PER_PIC (overrun), the next state is ERR.
- PASS_END (1 cycle): pix_cnt, out_cnt and wd_cnt are cleared.
  - If kernel_sel==NUM_KERNELS-1, the next state is DONE.
  - Otherwise kernel_sel increments and the next state is LAUNCH.
- DONE: layer_done=1 for one cycle; next state IDLE; busy drops in IDLE.
- ERR: err=1 (sticky), busy=0; next state IDLE. err stays high until the next accepted start or reset.
- Simultaneous events:
  - Timeout terminal count and out_valid in the same cycle: out_valid wins (written, no fault).
  - Overrun and final out_valid in the same cycle: ERR wins; the final write is still issued.
- start_flag is ignored outside IDLE, including during DONE/ERR; no queuing.
- out_valid outside STREAM is ignored (no write, no count). pic_valid outside STREAM is ignored.
- Counters never wrap in normal operation. Exceeding a terminal count is a fault (ERR), never a silent wrap.

Test Plan:
(Params NUM_KERNELS=2, PIX_PER_PIC=9, OUT_PER_PASS=4, TIMEOUT=16 unless stated.)
- Nominal: reset, pulse start_flag at cycle 10; model gives 9 pic_valid and 4 out_valid per launch -> pic_start high cycles 11 and one cycle after pass 0 PASS_END; wr_addr 0,1,2,3 then 4,5,6,7; single layer_done pulse; err=0.
- Start while busy: second start_flag pulse during pass 0 STREAM -> ignored, exactly 2 pic_start pulses total, one layer_done.
- Timeout: after launch, no out_valid for 16 cycles -> err=1 on cycle 17 after LAUNCH, busy=0, no layer_done; next start_flag clears err and relaunches with kernel_sel=0.
- Overrun: 10 pic_valid in pass 0 -> ERR entered on the 10th strobe, err=1, no further pic_start.
- Reset mid-operation: assert sys_rst for 1 cycle during pass 1 after 2 writes -> all outputs 0 next cycle, state IDLE, no layer_done; fresh start completes nominally.
- Boundary: out_valid coincident with watchdog count 15 -> write issued, no err; NUM_KERNELS=1 build -> single pass, wr_addr 0..3, layer_done.
